// File: rtl/ras_pkg.sv
// Shared types and width helpers for the checkpointed return-address stack.
// Record fields are sized for the largest supported build; unused upper bits have no loads.
package ras_pkg;

  localparam int unsigned RAS_WIDTH_DEF = 32;
  localparam int unsigned RAS_DEPTH_DEF = 16;
  localparam int unsigned RAS_CKPTS_DEF = 8;

  // Upper limits: WIDTH <= 64, DEPTH <= 65535.
  localparam int unsigned REC_DATA_W = 64;
  localparam int unsigned REC_TOS_W  = 16;
  localparam int unsigned REC_CNT_W  = 17;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned RAS_PTR_W_DEF = idx_w(RAS_DEPTH_DEF);
  localparam int unsigned RAS_CNT_W_DEF = cnt_w(RAS_DEPTH_DEF);
  localparam int unsigned RAS_ID_W_DEF  = idx_w(RAS_CKPTS_DEF);

  typedef struct packed {
    logic [REC_TOS_W-1:0]  tos;
    logic [REC_CNT_W-1:0]  cnt;
    logic [REC_DATA_W-1:0] data;
  } ckpt_rec_t;

endpackage

// File: rtl/ras_ckpt_queue.sv
// Circular queue of stack checkpoints: allocate at tail, commit at head,
// and truncate back to a given slot on restore.
module ras_ckpt_queue
  import ras_pkg::*;
#(
  parameter int unsigned CKPTS = RAS_CKPTS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_ni,
  input  logic                      alloc_i,
  input  logic                      commit_i,
  input  logic                      restore_i,
  input  logic [idx_w(CKPTS)-1:0]   restore_id_i,
  input  ckpt_rec_t                 rec_i,
  output ckpt_rec_t                 rec_o,
  output logic                      gnt_o,
  output logic [idx_w(CKPTS)-1:0]   id_o,
  output logic                      full_o
);

  localparam int unsigned ID_W  = idx_w(CKPTS);
  localparam int unsigned OCC_W = cnt_w(CKPTS);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(CKPTS - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(CKPTS);

  ckpt_rec_t        slots_q [CKPTS];
  logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             commit_ok;

  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
    return (id == ID_LAST) ? '0 : id + ID_W'(1);
  endfunction

  assign full_o    = (occ_q == OCC_FULL);
  assign gnt_o     = alloc_i && !restore_i && !full_o;
  assign id_o      = tail_q;
  assign commit_ok = commit_i && (occ_q != '0);
  assign rec_o     = slots_q[restore_id_i];

  always_comb begin
    head_d = commit_ok ? id_inc(head_q) : head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (restore_i) begin
      // Live slots become [head_d, restore_id); the restored slot itself is freed.
      tail_d = restore_id_i;
      if (restore_id_i >= head_d) occ_d = OCC_W'(restore_id_i - head_d);
      else                        occ_d = (OCC_FULL - OCC_W'(head_d)) + OCC_W'(restore_id_i);
    end else begin
      if (gnt_o) tail_d = id_inc(tail_q);
      unique case ({gnt_o, commit_ok})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_o) slots_q[tail_q] <= rec_i;
  end

endmodule

// File: rtl/ras_ckpt.sv
// Return-address stack with overwrite-on-overflow and branch checkpoints that
// save {tos, cnt, top data} so a mispredict can roll the stack back.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int unsigned WIDTH = RAS_WIDTH_DEF,
  parameter int unsigned DEPTH = RAS_DEPTH_DEF,
  parameter int unsigned CKPTS = RAS_CKPTS_DEF
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        din_i,
  output logic [WIDTH-1:0]        dout_o,
  output logic                    valid_o,
  output logic [cnt_w(DEPTH)-1:0] count_o,
  input  logic                    ckpt_req_i,
  output logic                    ckpt_gnt_o,
  output logic [idx_w(CKPTS)-1:0] ckpt_id_o,
  output logic                    ckpt_full_o,
  input  logic                    commit_i,
  input  logic                    restore_i,
  input  logic [idx_w(CKPTS)-1:0] restore_id_i
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam logic [PTR_W-1:0] TOS_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d, tos_inc, tos_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data, top_d;
  logic             ckpt_alloc;
  ckpt_rec_t        alloc_rec, restore_rec;
  logic             unused_rec;

  assign tos_inc = (tos_q == TOS_LAST) ? '0 : tos_q + PTR_W'(1);
  assign tos_dec = (tos_q == '0) ? TOS_LAST : tos_q - PTR_W'(1);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tos_q;
    wr_data = din_i;
    if (restore_i) begin
      tos_d   = PTR_W'(restore_rec.tos);
      cnt_d   = CNT_W'(restore_rec.cnt);
      wr_en   = 1'b1;
      wr_idx  = PTR_W'(restore_rec.tos);
      wr_data = WIDTH'(restore_rec.data);
    end else if (push_i && pop_i && cnt_q != '0) begin
      wr_en = 1'b1;
    end else if (push_i) begin
      // At full depth the new top lands on the oldest entry.
      tos_d  = tos_inc;
      wr_en  = 1'b1;
      wr_idx = tos_inc;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && cnt_q != '0) begin
      tos_d = tos_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign top_d = (wr_en && wr_idx == tos_d) ? wr_data : mem_q[tos_d];

  always_comb begin
    alloc_rec      = '0;
    alloc_rec.tos  = REC_TOS_W'(tos_d);
    alloc_rec.cnt  = REC_CNT_W'(cnt_d);
    alloc_rec.data = REC_DATA_W'(top_d);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q <= TOS_LAST;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the array is not reset; outputs mask it whenever cnt is zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign dout_o  = (cnt_q != '0) ? mem_q[tos_q] : '0;
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

  assign ckpt_alloc = ckpt_req_i && !restore_i && rst_ni;

  ras_ckpt_queue #(.CKPTS(CKPTS)) u_queue (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .alloc_i      (ckpt_alloc),
    .commit_i     (commit_i),
    .restore_i    (restore_i),
    .restore_id_i (restore_id_i),
    .rec_i        (alloc_rec),
    .rec_o        (restore_rec),
    .gnt_o        (ckpt_gnt_o),
    .id_o         (ckpt_id_o),
    .full_o       (ckpt_full_o)
  );

  // Only the low bits of the wide record are consumed.
  assign unused_rec = ^restore_rec;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: a queue-based model predicts every output each cycle,
// and literal expectations pin the model on the key scenarios.
module tb_ras_ckpt;

  localparam int W = 32;
  localparam int D = 16;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         push_i = 1'b0, pop_i = 1'b0, ckpt_req_i = 1'b0;
  logic         commit_i = 1'b0, restore_i = 1'b0;
  logic [W-1:0] din_i = '0;
  logic [2:0]   restore_id_i = '0;
  logic [W-1:0] dout_o;
  logic         valid_o, ckpt_gnt_o, ckpt_full_o;
  logic [4:0]   count_o;
  logic [2:0]   ckpt_id_o;

  always #5 clk = ~clk;

  ras_ckpt #(.WIDTH(W), .DEPTH(D), .CKPTS(C)) dut (
    .clk(clk), .rst_ni(rst_ni), .push_i(push_i), .pop_i(pop_i), .din_i(din_i),
    .dout_o(dout_o), .valid_o(valid_o), .count_o(count_o),
    .ckpt_req_i(ckpt_req_i), .ckpt_gnt_o(ckpt_gnt_o), .ckpt_id_o(ckpt_id_o),
    .ckpt_full_o(ckpt_full_o), .commit_i(commit_i), .restore_i(restore_i),
    .restore_id_i(restore_id_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: circular stack with spec arithmetic, checkpoints as an ordered list of records.
  typedef struct { int id; int tos; int cnt; logic [W-1:0] data; } ck_t;
  logic [W-1:0] m_arr [D];
  int           m_tos, m_cnt, m_next_id;
  ck_t          m_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_top();
    return (m_cnt > 0) ? m_arr[m_tos] : '0;
  endfunction

  function automatic int find_slot(input int id);
    foreach (m_q[i]) if (m_q[i].id == id) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_tos = D - 1;
    m_cnt = 0;
    m_next_id = 0;
    m_q.delete();
  endtask

  task automatic check_outputs();
    check("dout", dout_o, m_top());
    check("valid", valid_o, m_cnt != 0);
    check("count", count_o, m_cnt);
    check("ckpt_full", ckpt_full_o, m_q.size() == C);
  endtask

  task automatic model_apply(input logic p, input logic po, input logic [W-1:0] d,
                             input logic cm, input logic rs, input int rid, input logic g);
    int k;
    if (cm && m_q.size() > 0) void'(m_q.pop_front());
    if (rs) begin
      k = find_slot(rid);
      if (k >= 0) begin
        m_tos = m_q[k].tos;
        m_cnt = m_q[k].cnt;
        m_arr[m_tos] = m_q[k].data;
        while (m_q.size() > k) void'(m_q.pop_back());
      end
      m_next_id = rid;
    end else begin
      if (p && po && m_cnt > 0) begin
        m_arr[m_tos] = d;
      end else if (p) begin
        m_tos = (m_tos + 1) % D;
        m_arr[m_tos] = d;
        m_cnt = (m_cnt < D) ? m_cnt + 1 : D;
      end else if (po && m_cnt > 0) begin
        m_tos = (m_tos + D - 1) % D;
        m_cnt--;
      end
      if (g) begin
        m_q.push_back('{id: m_next_id, tos: m_tos, cnt: m_cnt, data: m_arr[m_tos]});
        m_next_id = (m_next_id + 1) % C;
      end
    end
  endtask

  // Entered at a falling edge; drives one cycle of inputs and checks every output.
  task automatic step(input logic p, input logic po, input logic [W-1:0] d, input logic rq,
                      input logic cm, input logic rs, input int rid,
                      output logic g, output logic [2:0] gid);
    logic exp_g;
    push_i = p; pop_i = po; din_i = d; ckpt_req_i = rq;
    commit_i = cm; restore_i = rs; restore_id_i = 3'(rid);
    #1;
    exp_g = rq && !rs && (m_q.size() < C);
    g   = ckpt_gnt_o;
    gid = ckpt_id_o;
    check("ckpt_gnt", g, exp_g);
    if (exp_g) check("ckpt_id", gid, m_next_id);
    if (rs) begin
      assert (find_slot(rid) >= 0)
        else $error("illegal restore: slot %0d is not occupied", rid);
      assert (!(cm && m_q.size() > 0 && m_q[0].id == rid))
        else $error("illegal restore: slot %0d is committed in the same cycle", rid);
    end
    @(posedge clk);
    model_apply(p, po, d, cm, rs, rid, exp_g);
    @(negedge clk);
    push_i = 0; pop_i = 0; ckpt_req_i = 0; commit_i = 0; restore_i = 0;
    check_outputs();
  endtask

  logic       g;
  logic [2:0] gid;

  task automatic push(input logic [W-1:0] d); step(1, 0, d, 0, 0, 0, 0, g, gid); endtask
  task automatic pop();                       step(0, 1, '0, 0, 0, 0, 0, g, gid); endtask
  task automatic ckpt();                      step(0, 0, '0, 1, 0, 0, 0, g, gid); endtask
  task automatic commit();                    step(0, 0, '0, 0, 1, 0, 0, g, gid); endtask
  task automatic restore(input int id);       step(0, 0, '0, 0, 0, 1, id, g, gid); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    ckpt_req_i = 1;
    #3;
    check("rst_dout", dout_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_gnt", ckpt_gnt_o, 0);
    check("rst_full", ckpt_full_o, 0);
    @(negedge clk);
    @(negedge clk);
    ckpt_req_i = 0;
    rst_ni = 1;

    // Pop at reset state, then first push.
    pop();
    check("s2_pop_count", count_o, 0);
    check("s2_pop_dout", dout_o, 0);
    push(32'hA0);
    check("s2_push_dout", dout_o, 32'hA0);
    check("s2_push_count", count_o, 1);
    pop();

    // Overflow overwrites the oldest entry.
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    push(32'h200);
    check("s1_count", count_o, 16);
    check("s1_dout", dout_o, 32'h200);
    for (int i = 0; i < 15; i++) pop();
    check("s1_last_dout", dout_o, 32'h101);
    pop();
    check("s1_empty_valid", valid_o, 0);

    // Checkpoint, disturb the top, restore.
    push(32'h10);
    push(32'h20);
    ckpt();
    check("s3_gnt", g, 1);
    check("s3_id", gid, 0);
    pop();
    push(32'h99);
    restore(0);
    check("s3_dout", dout_o, 32'h20);
    check("s3_count", count_o, 2);
    check("s3_full", ckpt_full_o, 0);

    // Fill all slots, refuse, commit one, wrap.
    for (int i = 0; i < C; i++) begin
      ckpt();
      check("s4_fill_id", gid, i);
    end
    check("s4_full", ckpt_full_o, 1);
    ckpt();
    check("s4_refused", g, 0);
    commit();
    check("s4_not_full", ckpt_full_o, 0);
    ckpt();
    check("s4_wrap_gnt", g, 1);
    check("s4_wrap_id", gid, 0);
    for (int i = 0; i < C + 1; i++) commit();

    // Push+pop+checkpoint in one cycle captures the replaced top.
    step(1, 1, 32'h30, 1, 0, 0, 0, g, gid);
    check("s5_id", gid, 1);
    check("s5_dout", dout_o, 32'h30);
    check("s5_count", count_o, 2);
    push(32'h44);
    restore(1);
    check("s5_restore_dout", dout_o, 32'h30);
    check("s5_restore_count", count_o, 2);

    // Restore wins over a simultaneous push and request.
    ckpt();
    push(32'h66);
    step(1, 0, 32'h55, 1, 0, 1, 1, g, gid);
    check("s6_gnt", g, 0);
    check("s6_dout", dout_o, 32'h30);
    check("s6_count", count_o, 2);

    // Commit of the oldest plus restore of the next in one cycle.
    ckpt();
    push(32'h77);
    ckpt();
    push(32'h88);
    step(0, 0, '0, 0, 1, 1, 2, g, gid);
    check("s7_dout", dout_o, 32'h77);
    check("s7_count", count_o, 3);

    // Mixed traffic, model-checked every cycle.
    for (int i = 0; i < 40; i++)
      step(i % 3 != 2, i % 4 == 3, 32'h1000 + i, i % 5 == 0, i % 7 == 6, 0, 0, g, gid);

    // Asynchronous reset mid-operation.
    push_i = 1; din_i = 32'hDEAD;
    #2;
    rst_ni = 0;
    push_i = 0;
    #1;
    model_reset();
    check("mid_rst_dout", dout_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_full", ckpt_full_o, 0);
    @(negedge clk);
    rst_ni = 1;
    push(32'hBEEF);
    check("post_rst_dout", dout_o, 32'hBEEF);
    check("post_rst_count", count_o, 1);
    ckpt();
    check("post_rst_id", gid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH, 32, return-address width.
- DEPTH, 16, stack entries (any value >= 2; power of two not required).
- CKPTS, 8, checkpoint slots (>= 2).
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_ni, in, 1, reset: asynchronous, active-low.
- push_i, in, 1, call: push din_i.
- pop_i, in, 1, return: pop top.
- din_i, in, WIDTH, address to push.
- dout_o, out, WIDTH, current top of stack.
- valid_o, out, 1, stack non-empty.
- count_o, out, clog2(DEPTH+1), live entry count.
- ckpt_req_i, in, 1, request a checkpoint (branch predicted).
- ckpt_gnt_o, out, 1, checkpoint taken this cycle.
- ckpt_id_o, out, clog2(CKPTS), slot granted.
- ckpt_full_o, out, 1, no free slot.
- commit_i, in, 1, free the oldest checkpoint (branch resolved correct).
- restore_i, in, 1, mispredict: roll back to restore_id_i.
- restore_id_i, in, clog2(CKPTS), slot to restore.

Function
REQ-003 State: tos (index of top entry), cnt (0..DEPTH), flop array mem[DEPTH]; checkpoint circular queue of head, tail, occupancy, and per slot {tos, cnt, top data}.
REQ-004 dout_o = mem[tos] combinationally from registered state when cnt > 0; dout_o = 0 when cnt = 0; valid_o = (cnt != 0).
REQ-005 Push only: tos <= (tos+1) mod DEPTH, mem[new tos] <= din_i, cnt <= min(cnt+1, DEPTH); wrap from DEPTH-1 to 0 is explicit.
REQ-006 Push at cnt = DEPTH overwrites the oldest entry; cnt stays DEPTH.
REQ-007 Pop only: tos <= (tos-1) mod DEPTH, cnt <= cnt-1; pop at cnt = 0 is ignored (no state change).
REQ-008 Push and pop together: mem[tos] <= din_i, tos and cnt unchanged; at cnt = 0, behaves as push only.
REQ-009 ckpt_req_i with occupancy < CKPTS: ckpt_gnt_o = 1 and ckpt_id_o = tail, both combinational in the same cycle; the slot stores the post-op values of {tos, cnt, mem[tos]} for this cycle's push/pop; tail advances mod CKPTS.
REQ-010 ckpt_req_i with occupancy = CKPTS: ckpt_gnt_o = 0; nothing stored; ckpt_full_o = (occupancy == CKPTS).
REQ-011 commit_i advances head; commit_i at occupancy 0 is ignored.
REQ-012 restore_i has priority: this cycle's push, pop and ckpt_req_i are ignored (ckpt_gnt_o = 0).
- Restore loads tos and cnt from slot restore_id_i and writes the saved top data to mem[saved tos].
- Restore frees slot restore_id_i and all younger slots: tail <= restore_id_i.
REQ-013 commit_i and restore_i in the same cycle: the commit applies first, then the restore; restore_id_i must not equal the committed slot. A bench assertion flags that case as illegal.
REQ-014 restore_id_i outside the occupied range is illegal; a bench assertion flags it.
REQ-015 Latency: every state change is visible on outputs one cycle after the requesting edge.

Reset
REQ-016 On rst_ni low, asynchronously: tos = DEPTH-1, cnt = 0, head = tail = 0, occupancy = 0.
- Outputs during and after reset: dout_o = 0, valid_o = 0, count_o = 0, ckpt_gnt_o = 0, ckpt_full_o = 0.
REQ-017 mem and checkpoint payloads are not reset; no output may depend on them while cnt = 0 or the slot is free.
REQ-018 Reset asserted mid-operation discards all pending and stored state; the first post-reset push lands in mem[0].

Structure
REQ-019 Shared package ras_pkg holds:
- the checkpoint record type {tos, cnt, data};
- width helper constants derived from DEPTH and CKPTS.
REQ-020 The checkpoint queue is a sub-module ras_ckpt_queue: allocate, commit and restore-truncate, with occupancy and full flags. The stack array and pointer logic stay in ras_ckpt.

Verification
REQ-021 Directed scenarios:
- DEPTH=16: push 0x100..0x10F, then push 0x200 -> count_o = 16, dout_o = 0x200; after 16 pops valid_o = 0, and oldest entry 0x100 is gone.
- Pop at reset state -> count_o = 0, dout_o = 0, no pointer movement; a next push of 0xA0 -> dout_o = 0xA0, count_o = 1.
- Push 0x10, 0x20; checkpoint (id 0); pop; push 0x99; restore id 0 -> dout_o = 0x20, count_o = 2, free slots = CKPTS.
- Allocate CKPTS checkpoints -> ckpt_full_o = 1, next request gets ckpt_gnt_o = 0; one commit -> ckpt_full_o = 0, next grant returns the wrapped id.
- Same cycle push 0x30 + pop + ckpt_req on top 0x20 -> top = 0x30, count unchanged; restore of that slot returns dout_o = 0x30.
- restore_i together with push 0x55 -> push ignored, state equals the checkpoint.
